// File: rtl/bcd_display_pkg.sv
// Shared types and constants for the binary-to-BCD display encoder.
// Digit codes are {enable, nibble}; the state enum is used by the encoder FSM.
package bcd_display_pkg;
    localparam int          NUM_DIGITS        = 8;
    localparam logic [31:0] MAX_DISPLAY_VALUE = 32'd99_999_999;

    typedef logic [4:0] hex_digit_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_PUBLISH
    } bcd_state_t;
endpackage

// File: rtl/bcd_add3_digit.sv
// Double-dabble digit correction: adds 3 to a BCD digit of 5 or more.
// Purely combinational, zero latency, no flow control.
module bcd_add3_digit (
    input  logic [3:0] i_digit,
    output logic [3:0] o_digit
);
    assign o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
endmodule

// File: rtl/bcd_display_encoder.sv
// Sequential binary-to-BCD (shift-and-add-3) converter feeding eight {enable, nibble} display digits.
// Latency BIN_WIDTH+1 cycles from the accepting edge to Done; Start is ignored while Busy.
// Optional build macro LEADING_ZERO_BLANK_EN disables the enables of leading zero digits.
module bcd_display_encoder
    import bcd_display_pkg::*;
#(
    parameter int BIN_WIDTH = 27
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 Start,
    input  logic [BIN_WIDTH-1:0] Binary_value,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Overflow,
    output logic [4:0]           hex_values [7:0]
);
    localparam logic [4:0] LAST_CNT = 5'(BIN_WIDTH - 1);

    bcd_state_t           r_state;
    bcd_state_t           w_next_state;
    logic [BIN_WIDTH-1:0] r_bin;
    logic [31:0]          r_bcd;
    logic [4:0]           r_cnt;
    logic                 r_ovf_cap;
    logic                 r_ovf;
    logic                 r_done;
    hex_digit_t           r_hex      [NUM_DIGITS];
    hex_digit_t           w_hex_next [NUM_DIGITS];
    logic [31:0]          w_adj;
    logic [31:0]          w_shifted;
    logic                 w_ovf_in;

    // Only a 27-bit input can exceed eight decimal digits.
    assign w_ovf_in = (BIN_WIDTH >= 27) && (32'(Binary_value) > MAX_DISPLAY_VALUE);

    genvar g;
    generate
        for (g = 0; g < NUM_DIGITS; g++) begin : g_add3
            bcd_add3_digit u_add3 (
                .i_digit (r_bcd[4*g +: 4]),
                .o_digit (w_adj[4*g +: 4])
            );
        end
    endgenerate

    assign w_shifted = {w_adj[30:0], r_bin[BIN_WIDTH-1]};

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:    if (Start) w_next_state = S_CONVERT;
            S_CONVERT: if (r_cnt == LAST_CNT) w_next_state = S_PUBLISH;
            S_PUBLISH: w_next_state = S_IDLE;
            default:   w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic v_seen;
        v_seen = 1'b0;
`endif
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
`ifdef LEADING_ZERO_BLANK_EN
            v_seen        = v_seen | (r_bcd[4*k +: 4] != 4'd0) | (k == 0);
            w_hex_next[k] = r_ovf_cap ? 5'h1F : {v_seen, r_bcd[4*k +: 4]};
`else
            w_hex_next[k] = r_ovf_cap ? 5'h1F : {1'b1, r_bcd[4*k +: 4]};
`endif
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_bin     <= '0;
            r_bcd     <= '0;
            r_cnt     <= '0;
            r_ovf_cap <= 1'b0;
            r_ovf     <= 1'b0;
            r_done    <= 1'b0;
            r_hex     <= '{default: '0};
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (Start) begin
                        r_bin     <= Binary_value;
                        r_bcd     <= '0;
                        r_cnt     <= '0;
                        r_ovf_cap <= w_ovf_in;
                    end
                end
                S_CONVERT: begin
                    r_bcd     <= w_shifted;
                    r_bin     <= {r_bin[BIN_WIDTH-2:0], 1'b0};
                    r_cnt     <= r_cnt + 5'd1;
                    // A digit pushed out of the accumulator can never be displayed.
                    r_ovf_cap <= r_ovf_cap | w_adj[31];
                end
                S_PUBLISH: begin
                    r_hex  <= w_hex_next;
                    r_ovf  <= r_ovf_cap;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Busy     = (r_state != S_IDLE);
    assign Done     = r_done;
    assign Overflow = r_ovf;

    always_comb begin
        for (int k = 0; k < NUM_DIGITS; k++) begin
            hex_values[k] = r_hex[k];
        end
    end
endmodule

// File: tb/tb_bcd_display_encoder.sv
// Directed, table-driven bench for bcd_display_encoder at BIN_WIDTH=27.
// Expected digits are hand-written BCD constants with per-build enable masks.
module tb_bcd_display_encoder;
    logic        Clock = 1'b0;
    logic        Resetn;
    logic        Start;
    logic [26:0] Binary_value;
    logic        Busy;
    logic        Done;
    logic        Overflow;
    logic [4:0]  hex_values [7:0];

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [26:0] value;
        logic [31:0] bcd;
        logic [7:0]  en_plain;
        logic [7:0]  en_blank;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    bcd_display_encoder #(.BIN_WIDTH(27)) dut (
        .Clock        (Clock),
        .Resetn       (Resetn),
        .Start        (Start),
        .Binary_value (Binary_value),
        .Busy         (Busy),
        .Done         (Done),
        .Overflow     (Overflow),
        .hex_values   (hex_values)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    function automatic logic [39:0] hex_got();
        logic [39:0] r;
        for (int k = 0; k < 8; k++) r[k*5 +: 5] = hex_values[k];
        return r;
    endfunction

    function automatic logic [39:0] mk(input logic [31:0] bcd, input logic [7:0] en, input logic ovf);
        logic [39:0] r;
        for (int k = 0; k < 8; k++) r[k*5 +: 5] = ovf ? 5'h1F : {en[k], bcd[k*4 +: 4]};
        return r;
    endfunction

    function automatic logic [7:0] pick_en(input logic [7:0] plain, input logic [7:0] blank);
`ifdef LEADING_ZERO_BLANK_EN
        return blank;
`else
        return plain;
`endif
    endfunction

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 100; n++) begin
            @(posedge Clock); #1;
            if (Done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the Done edge.
    task automatic run(input logic [26:0] v, input logic [39:0] exph, input logic expovf, input string tag);
        int lat;
        Start = 1'b1;
        Binary_value = v;
        @(posedge Clock); #1;
        Start = 1'b0;
        check({tag, " busy"}, 64'(Busy), 64'd1);
        wait_done(lat);
        check({tag, " latency"}, 64'(lat), 64'd28);
        check({tag, " hex"}, 64'(hex_got()), 64'(exph));
        check({tag, " overflow"}, 64'(Overflow), 64'(expovf));
        check({tag, " busy_low"}, 64'(Busy), 64'd0);
    endtask

    initial begin
        int lat;
        int seen;

        vecs[0] = '{27'd12345678,  32'h12345678, 8'hFF, 8'hFF, 1'b0};
        vecs[1] = '{27'd99999999,  32'h99999999, 8'hFF, 8'hFF, 1'b0};
        vecs[2] = '{27'd100000000, 32'h00000000, 8'hFF, 8'hFF, 1'b1};
        vecs[3] = '{27'd305,       32'h00000305, 8'hFF, 8'h07, 1'b0};
        vecs[4] = '{27'd0,         32'h00000000, 8'hFF, 8'h01, 1'b0};
        vecs[5] = '{27'd134217727, 32'h00000000, 8'hFF, 8'hFF, 1'b1};
        vecs[6] = '{27'd10000000,  32'h10000000, 8'hFF, 8'hFF, 1'b0};
        vecs[7] = '{27'd1,         32'h00000001, 8'hFF, 8'h01, 1'b0};
        vecs[8] = '{27'd90000009,  32'h90000009, 8'hFF, 8'hFF, 1'b0};
        vecs[9] = '{27'd4096,      32'h00004096, 8'hFF, 8'h0F, 1'b0};

        Resetn = 1'b0;
        Start = 1'b0;
        Binary_value = '0;
        repeat (3) @(posedge Clock);
        #1;
        Resetn = 1'b1;
        check("reset hex", 64'(hex_got()), 64'd0);
        check("reset busy", 64'(Busy), 64'd0);
        check("reset done", 64'(Done), 64'd0);
        check("reset overflow", 64'(Overflow), 64'd0);

        seen = 0;
        repeat (50) begin
            @(posedge Clock); #1;
            if (Done !== 1'b0 || Busy !== 1'b0) seen++;
        end
        check("idle no done", 64'(seen), 64'd0);

        for (int i = 0; i < 10; i++) begin
            run(vecs[i].value,
                mk(vecs[i].bcd, pick_en(vecs[i].en_plain, vecs[i].en_blank), vecs[i].ovf),
                vecs[i].ovf, $sformatf("vec%0d", i));
            @(posedge Clock); #1;
            check($sformatf("vec%0d done_pulse", i), 64'(Done), 64'd0);
        end

        // Second request during a conversion must be dropped.
        Start = 1'b1;
        Binary_value = 27'd42;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (4) begin
            @(posedge Clock); #1;
        end
        Start = 1'b1;
        Binary_value = 27'd77;
        @(posedge Clock); #1;
        Start = 1'b0;
        wait_done(lat);
        check("ignored latency", 64'(lat + 5), 64'd28);
        check("ignored hex", 64'(hex_got()), 64'(mk(32'h42, pick_en(8'hFF, 8'h03), 1'b0)));

        // Start presented on the Done cycle is accepted.
        run(27'd77, mk(32'h77, pick_en(8'hFF, 8'h03), 1'b0), 1'b0, "start_on_done");

        run(27'd100000000, mk(32'h0, 8'hFF, 1'b1), 1'b1, "pre_reset_ovf");

        Start = 1'b1;
        Binary_value = 27'd12345678;
        @(posedge Clock); #1;
        Start = 1'b0;
        repeat (9) begin
            @(posedge Clock); #1;
        end
        Resetn = 1'b0;
        #1;
        check("abort hex", 64'(hex_got()), 64'd0);
        check("abort busy", 64'(Busy), 64'd0);
        check("abort done", 64'(Done), 64'd0);
        check("abort overflow", 64'(Overflow), 64'd0);
        @(posedge Clock); #1;
        Resetn = 1'b1;
        seen = 0;
        repeat (40) begin
            @(posedge Clock); #1;
            if (Done !== 1'b0) seen++;
        end
        check("abort no done", 64'(seen), 64'd0);

        run(27'd12345678, mk(32'h12345678, 8'hFF, 1'b0), 1'b0, "after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
